// File: rtl/uart_tx_arbiter_if.sv
// Bus-side requesters and TX FIFO write port of the UART TX arbiter.
// master drives requests and FIFO status; slave is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [IW-1:0]                 grant_id;
  logic                          busy;

  modport master (
    output req_valid,
    output req_last,
    output req_data,
    output fifo_full,
    input  req_ready,
    input  fifo_wr_en,
    input  fifo_wr_data,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_last,
    input  req_data,
    input  fifo_full,
    output req_ready,
    output fifo_wr_en,
    output fifo_wr_data,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART TX FIFO write port, bounded bursts.
// Define UART_ARB_TIMEOUT_EN to release owners that stop sending.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int TIMEOUT    = 16
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IW-1:0]         rr_q;
  logic [IW-1:0]         rr_d;
  logic [IW-1:0]         gid_q;
  logic [IW-1:0]         gid_d;
  logic [IW-1:0]         gid_inc;
  logic [IW-1:0]         sel_idx;
  logic [IW-1:0]         probe;
  logic [BW-1:0]         burst_q;
  logic [BW-1:0]         burst_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] slice;
  logic                  sel_any;
  logic                  own_valid;
  logic                  own_last;
  logic                  xfer;
  logic                  burst_end;
  logic                  stall_exp;
  int                    j;

  assign own_valid = bus.req_valid[gid_q];
  assign own_last  = bus.req_last[gid_q];
  assign burst_end = (burst_q == BW'(MAX_BURST - 1));
  assign gid_inc   = (gid_q == IW'(NUM_REQ - 1))
                   ? '0 : gid_q + 1'b1;

  assign bus.busy     = (state_q == GRANT);
  assign bus.grant_id = gid_q;

  // Lowest offset from rr_q wins, so scan offsets high to low.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = rr_q;
    probe   = '0;
    j       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      probe = IW'(j);
      if (bus.req_valid[probe]) begin
        sel_any = 1'b1;
        sel_idx = probe;
      end
    end
  end

  always_comb begin
    slice = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == IW'(i))
        slice = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_q;
  logic [SW-1:0] stall_d;

  // Full-FIFO cycles are not the owner's fault; hold the count.
  always_comb begin
    stall_d   = stall_q;
    stall_exp = 1'b0;
    if (state_q != GRANT || xfer) begin
      stall_d = '0;
    end else if (!own_valid && !bus.fifo_full) begin
      if (stall_q == SW'(TIMEOUT - 1))
        stall_exp = 1'b1;
      else
        stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign stall_exp = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    gid_d            = gid_q;
    burst_d          = burst_q;
    data_d           = data_q;
    xfer             = 1'b0;
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = data_q;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          state_d = GRANT;
          gid_d   = sel_idx;
          burst_d = '0;
        end
      end
      GRANT: begin
        xfer                 = own_valid & ~bus.fifo_full;
        bus.fifo_wr_en       = xfer;
        bus.req_ready[gid_q] = xfer;
        bus.fifo_wr_data     = slice;
        data_d               = slice;
        if (xfer) burst_d = burst_q + 1'b1;
        if ((xfer && (own_last || burst_end))
            || stall_exp) begin
          rr_d    = gid_inc;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      burst_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      burst_q <= burst_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, 32-bit, burst 4).
// Requester sources replay queued words; writes are logged and checked.
module tb_uart_tx_arbiter;
  logic clk;
  logic reset;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(32),
    .MAX_BURST(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int cyc;
  bit rst_v;
  bit full_v;

  logic [31:0] qd [4][$];
  bit          ql [4][$];
  int          wr_cyc [$];
  logic [1:0]  wr_gid [$];
  logic [31:0] wr_dat [$];

  task automatic cycle();
    @(negedge clk);
    cyc++;
    reset = rst_v;
    bus.fifo_full = full_v;
    for (int i = 0; i < 4; i++) begin
      if (qd[i].size() > 0) begin
        bus.req_valid[i] = 1'b1;
        bus.req_last[i]  = ql[i][0];
        bus.req_data[i*32 +: 32] = qd[i][0];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
      end
    end
    #1;
    if (rst_v && bus.fifo_wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_gid.push_back(bus.grant_id);
      wr_dat.push_back(bus.fifo_wr_data);
    end
    for (int i = 0; i < 4; i++) begin
      if (rst_v && bus.req_ready[i] === 1'b1) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    end
  endtask

  task automatic push(int r, logic [31:0] d, bit l);
    qd[r].push_back(d);
    ql[r].push_back(l);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      qd[i].delete();
      ql[i].delete();
    end
    full_v = 1'b0;
  endtask

  task automatic clear_log();
    wr_cyc.delete();
    wr_gid.delete();
    wr_dat.delete();
  endtask

  task automatic rst_pulse();
    rst_v = 1'b0;
    cycle();
    rst_v = 1'b1;
  endtask

  task automatic test_reset();
    rst_v = 1'b0;
    cycle();
    cycle();
    rst_v = 1'b1;
    cycle();
    n_chk++;
    if (bus.busy !== 1'b0)
      $display("FAIL rst_busy got %b exp 0", bus.busy);
    else n_pass++;
    n_chk++;
    if (bus.fifo_wr_en !== 1'b0)
      $display("FAIL rst_wr_en got %b exp 0", bus.fifo_wr_en);
    else n_pass++;
    n_chk++;
    if (bus.req_ready !== 4'b0)
      $display("FAIL rst_ready got %b exp 0000", bus.req_ready);
    else n_pass++;
    n_chk++;
    if (bus.grant_id !== 2'd0)
      $display("FAIL rst_gid got %0d exp 0", bus.grant_id);
    else n_pass++;
    n_chk++;
    if (bus.fifo_wr_data !== 32'h0)
      $display("FAIL rst_data got %h exp 0", bus.fifo_wr_data);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] exp_d [3];
    exp_d = '{32'hA1, 32'hA2, 32'hA3};
    clear_all();
    clear_log();
    push(0, 32'hA1, 1'b0);
    push(0, 32'hA2, 1'b0);
    push(0, 32'hA3, 1'b1);
    cycle();
    n_chk++;
    if (bus.busy !== 1'b0 || bus.fifo_wr_en !== 1'b0)
      $display("FAIL single_idle got busy=%b wr=%b exp 0 0",
               bus.busy, bus.fifo_wr_en);
    else n_pass++;
    cycle();
    n_chk++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0)
      $display("FAIL single_grant got busy=%b gid=%0d exp 1 0",
               bus.busy, bus.grant_id);
    else n_pass++;
    repeat (3) cycle();
    n_chk++;
    if (bus.busy !== 1'b0)
      $display("FAIL single_release got busy=%b exp 0", bus.busy);
    else n_pass++;
    n_chk++;
    if (wr_dat.size() != 3)
      $display("FAIL single_count got %0d exp 3", wr_dat.size());
    else n_pass++;
    if (wr_dat.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (wr_dat[k] !== exp_d[k] || wr_gid[k] !== 2'd0)
          $display("FAIL single_w%0d got %h/%0d exp %h/0",
                   k, wr_dat[k], wr_gid[k], exp_d[k]);
        else n_pass++;
      end
      n_chk++;
      if (wr_cyc[2] - wr_cyc[0] != 2)
        $display("FAIL single_consec got span %0d exp 2",
                 wr_cyc[2] - wr_cyc[0]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g [5];
    logic [31:0] exp_d [5];
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
    clear_all();
    rst_pulse();
    clear_log();
    push(0, 32'hB0, 1'b1);
    push(0, 32'hB4, 1'b1);
    push(1, 32'hB1, 1'b1);
    push(2, 32'hB2, 1'b1);
    push(3, 32'hB3, 1'b1);
    repeat (11) cycle();
    n_chk++;
    if (wr_dat.size() != 5)
      $display("FAIL rr_count got %0d exp 5", wr_dat.size());
    else n_pass++;
    if (wr_dat.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        n_chk++;
        if (wr_gid[k] !== exp_g[k] || wr_dat[k] !== exp_d[k])
          $display("FAIL rr_w%0d got %0d/%h exp %0d/%h", k,
                   wr_gid[k], wr_dat[k], exp_g[k], exp_d[k]);
        else n_pass++;
      end
      for (int k = 1; k < 5; k++) begin
        n_chk++;
        if (wr_cyc[k] - wr_cyc[k-1] != 2)
          $display("FAIL rr_gap%0d got %0d exp 2",
                   k, wr_cyc[k] - wr_cyc[k-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_burst_limit();
    logic [1:0]  exp_g [7];
    logic [31:0] exp_d [7];
    exp_g = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2};
    exp_d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3,
              32'hD0, 32'hC4, 32'hC5};
    clear_all();
    rst_pulse();
    clear_log();
    for (int k = 0; k < 6; k++) push(2, 32'hC0 + k, 1'b0);
    push(3, 32'hD0, 1'b1);
    repeat (12) cycle();
    n_chk++;
    if (wr_dat.size() != 7)
      $display("FAIL burst_count got %0d exp 7", wr_dat.size());
    else n_pass++;
    if (wr_dat.size() == 7) begin
      for (int k = 0; k < 7; k++) begin
        n_chk++;
        if (wr_gid[k] !== exp_g[k] || wr_dat[k] !== exp_d[k])
          $display("FAIL burst_w%0d got %0d/%h exp %0d/%h", k,
                   wr_gid[k], wr_dat[k], exp_g[k], exp_d[k]);
        else n_pass++;
      end
      n_chk++;
      if (wr_cyc[4] - wr_cyc[3] != 2)
        $display("FAIL burst_gap got %0d exp 2",
                 wr_cyc[4] - wr_cyc[3]);
      else n_pass++;
    end
    n_chk++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 2'd2)
      $display("FAIL burst_hold got busy=%b gid=%0d exp 1 2",
               bus.busy, bus.grant_id);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [4];
    exp_d = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
    clear_all();
    rst_pulse();
    clear_log();
    for (int k = 0; k < 4; k++) push(1, 32'hE0 + k, k == 3);
    repeat (3) cycle();
    full_v = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_chk++;
      if ({bus.fifo_wr_en, bus.req_ready, bus.grant_id, bus.busy}
          !== {1'b0, 4'b0000, 2'd1, 1'b1})
        $display("FAIL bp_hold%0d got wr=%b rdy=%b gid=%0d busy=%b exp 0 0000 1 1",
                 k, bus.fifo_wr_en, bus.req_ready,
                 bus.grant_id, bus.busy);
      else n_pass++;
      n_chk++;
      if (bus.fifo_wr_data !== 32'hE2)
        $display("FAIL bp_data%0d got %h exp e2",
                 k, bus.fifo_wr_data);
      else n_pass++;
    end
    full_v = 1'b0;
    repeat (4) cycle();
    n_chk++;
    if (wr_dat.size() != 4)
      $display("FAIL bp_count got %0d exp 4", wr_dat.size());
    else n_pass++;
    if (wr_dat.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (wr_gid[k] !== 2'd1 || wr_dat[k] !== exp_d[k])
          $display("FAIL bp_w%0d got %0d/%h exp 1/%h", k,
                   wr_gid[k], wr_dat[k], exp_d[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_all();
    rst_pulse();
    clear_log();
    push(1, 32'h11, 1'b1);
    repeat (3) cycle();
    for (int k = 0; k < 4; k++) push(2, 32'hF0 + k, k == 3);
    repeat (3) cycle();
    push(0, 32'h10, 1'b1);
    rst_pulse();
    cycle();
    n_chk++;
    if ({bus.busy, bus.fifo_wr_en, bus.req_ready, bus.grant_id}
        !== {1'b0, 1'b0, 4'b0000, 2'd0}
        || bus.fifo_wr_data !== 32'h0)
      $display("FAIL mid_rst got busy=%b wr=%b rdy=%b gid=%0d data=%h exp all 0",
               bus.busy, bus.fifo_wr_en, bus.req_ready,
               bus.grant_id, bus.fifo_wr_data);
    else n_pass++;
    cycle();
    n_chk++;
    if (bus.fifo_wr_en !== 1'b1 || bus.grant_id !== 2'd0
        || bus.fifo_wr_data !== 32'h10)
      $display("FAIL mid_regrant got wr=%b gid=%0d data=%h exp 1 0 10",
               bus.fifo_wr_en, bus.grant_id, bus.fifo_wr_data);
    else n_pass++;
    n_chk++;
    if (wr_dat.size() < 3 || wr_dat[1] !== 32'hF0
        || wr_dat[2] !== 32'hF1)
      $display("FAIL mid_prefix got n=%0d exp F0,F1 before reset",
               wr_dat.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    clear_all();
    rst_pulse();
    clear_log();
    push(0, 32'h40, 1'b0);
    push(1, 32'h41, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    repeat (18) cycle();
    n_chk++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0)
      $display("FAIL to_held got busy=%b gid=%0d exp 1 0",
               bus.busy, bus.grant_id);
    else n_pass++;
    cycle();
    n_chk++;
    if (bus.busy !== 1'b0)
      $display("FAIL to_release got busy=%b exp 0", bus.busy);
    else n_pass++;
    cycle();
    n_chk++;
    if (wr_dat.size() != 2)
      $display("FAIL to_count got %0d exp 2", wr_dat.size());
    else n_pass++;
    if (wr_dat.size() == 2) begin
      n_chk++;
      if (wr_gid[1] !== 2'd1 || wr_dat[1] !== 32'h41
          || wr_cyc[1] - wr_cyc[0] != 18)
        $display("FAIL to_next got %0d/%h span %0d exp 1/41 span 18",
                 wr_gid[1], wr_dat[1], wr_cyc[1] - wr_cyc[0]);
      else n_pass++;
    end
`else
    repeat (30) cycle();
    n_chk++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0)
      $display("FAIL to_held got busy=%b gid=%0d exp 1 0",
               bus.busy, bus.grant_id);
    else n_pass++;
    n_chk++;
    if (wr_dat.size() != 1)
      $display("FAIL to_count got %0d exp 1", wr_dat.size());
    else n_pass++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    rst_v  = 1'b0;
    full_v = 1'b0;
    reset  = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_limit();
    test_backpressure();
    test_reset_mid_burst();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART TX FIFO write port among several bus-side requesters, e.g. CPU store path, debug monitor and DMA.
- Sits between the system-bus decode and the UART module's TX FIFO write interface.
- Grants one requester at a time for a bounded burst, so multi-word messages are not interleaved on txd.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, width of each data word.
- MAX_BURST, 4, maximum words accepted per grant before forced release (1..15).
- TIMEOUT, 16, idle-grant cycles before forced release (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_last  input  NUM_REQ  marks the final word of the requester's message.
- req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  word accepted this cycle (one-hot or zero).
- fifo_full  input  1  TX FIFO full flag.
- fifo_wr_en  output  1  TX FIFO write strobe.
- fifo_wr_data  output  DATA_WIDTH  word written to the TX FIFO.
- grant_id  output  clog2(NUM_REQ)  index of the current owner; valid while busy.
- busy  output  1  a grant is held.

Behaviour:
- Reset values (reset==0 sampled at a clk edge):
  - state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, busy=0.
  - req_ready=0, fifo_wr_en=0, fifo_wr_data=0.
- IDLE:
  - If any req_valid is set, select the first set bit searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Register the selection as grant_id, clear burst_cnt, go to GRANT.
  - Arbitration latency is 1 cycle; no word transfers in the IDLE cycle.
- GRANT:
  - Transfer condition xfer = req_valid[grant_id] & ~fifo_full.
  - fifo_wr_en = xfer and req_ready[grant_id] = xfer, both combinational in the same cycle; all other req_ready bits are 0.
  - fifo_wr_data = req_data slice of grant_id whenever state is GRANT; otherwise it holds its last value.
  - On xfer, burst_cnt increments.
  - Release when xfer & (req_last[grant_id] | burst_cnt==MAX_BURST-1).
  - On release: rr_ptr = grant_id+1 (wrapping at NUM_REQ), then go to IDLE.
  - While fifo_full=1 no transfer occurs; grant, burst_cnt and data selection all hold.
  - A deasserted req_valid from the owner does not release the grant (unless the optional feature is compiled in).
- busy=1 exactly while state is GRANT.
- Back-to-back grants carry at least one IDLE cycle between them.
- A requester that has not yet been granted may drop req_valid freely; it is simply not selected.
- Requester protocol: req_data and req_last must be held stable while req_valid=1 and req_ready=0. This is a bench assertion, not a design check.
- Reset mid-burst: the grant is aborted immediately, the partial message is not completed, and rr_ptr returns to 0.
- MAX_BURST=1: every accepted word releases the grant.
- Only one requester active: it is re-granted after each IDLE cycle.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter clears on every xfer and on entry to GRANT.
  - It increments each GRANT cycle where req_valid[grant_id]=0.
  - fifo_full cycles do not count, and the counter holds during them.
  - When the counter reaches TIMEOUT-1, the grant is released without a transfer, rr_ptr advances as for a normal release, and the state goes to IDLE.
- Not defined:
  - No counter logic is present.
  - The grant is held indefinitely until last or the burst limit.

Test Plan:
- Single requester: req_valid=0001, send 3 words 0xA1,0xA2,0xA3 with last on the third and fifo_full=0.
  - Required: grant_id=0 one cycle after valid; fifo_wr_en high for 3 consecutive cycles; data in order; busy drops after the third word.
- Round-robin fairness: all four requesters valid with 1-word messages, req_last=1 each.
  - Required: grant order 0,1,2,3,0; each write separated by one IDLE cycle.
- Burst limit: MAX_BURST=4, requester 2 sends 6 words with no last while requester 3 is also valid.
  - Required: 4 words from requester 2, grant to 3, then back to requester 2 for its remaining 2 words.
- Backpressure: hold fifo_full=1 for 5 cycles mid-burst.
  - Required: fifo_wr_en=0 and req_ready=0 throughout; grant_id unchanged; no word lost or duplicated after release.
- Reset mid-burst: drive reset=0 for 1 cycle after 2 of 4 words.
  - Required: all outputs zero, state IDLE, next grant starts from requester 0.
- Timeout (macro defined, TIMEOUT=16): the owner drops req_valid after 1 word.
  - Required: release after exactly 16 idle cycles; the next valid requester is granted. With the macro undefined, the grant is held.
